mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between the instruction-fetch requester (used during the decode phase) and the load/store requester (used during the execute phase). Only one transaction is outstanding at a time. Load/store has priority, and a streak limit prevents fetch starvation. The block sits between the pipeline phase logic and the memory, and exposes `busy` so the phase sequencer can stall.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; byte enables are DATA_WIDTH/8 bits wide.
- `LSU_STREAK_MAX`, 4: consecutive contested LSU grants allowed before fetch is forced through; range 1..15.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `if_req` in 1: fetch request; held high until `if_gnt`.
- `if_addr` in ADDR_WIDTH: fetch address; sampled at `if_gnt`.
- `if_gnt` out 1: one-cycle accept pulse; combinational in IDLE.
- `if_rvalid` out 1: one-cycle response pulse.
- `if_rdata` out DATA_WIDTH: fetch data; valid with `if_rvalid`.
- `lsu_req`, `lsu_we`, `lsu_addr`, `lsu_wdata`, `lsu_be` in 1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8: LSU request; sampled at `lsu_gnt`.
- `lsu_gnt` out 1: accept pulse.
- `lsu_rvalid` out 1: response pulse; for writes, signals completion.
- `lsu_rdata` out DATA_WIDTH: load data.
- `lsu_err` out 1: misaligned-request error; valid with `lsu_rvalid`.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` out: registered memory request.
- `mem_ready` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in DATA_WIDTH: read data.
- `busy` out 1: high whenever the FSM state is not IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT_RESP.
- **IDLE, arbitration:**
  - If only one requester is active, it wins.
  - If both are active, LSU wins unless `streak == LSU_STREAK_MAX`, in which case fetch wins.
  - The winner's `*_gnt` is asserted and its request fields are captured into registers.
  - The owner ID is latched, and the FSM goes to ISSUE.
- **Streak counter:**
  - Increments, saturating, on an LSU grant made while `if_req` is high.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- **ISSUE:**
  - `mem_req` = 1 with stable captured fields until `mem_ready`.
  - On `mem_ready`, a write goes to IDLE and a read goes to WAIT_RESP.
- **WAIT_RESP:** on `mem_rvalid`, capture `mem_rdata` into the owner's rdata register and go to IDLE.
- **Response pulses:**
  - The owner's `*_rvalid` pulses for exactly one cycle.
  - For reads, the pulse occurs the cycle after `mem_rvalid`.
  - For writes (LSU only), it occurs the cycle after `mem_ready`.
- `mem_rvalid` outside WAIT_RESP is ignored.
- `*_rdata` holds its value until the next response to the same requester.
- `if_addr`/`lsu_*` request fields are sampled only at grant; they may change afterwards.

## Timing
- **Reset values:**
  - All `*_gnt`, `*_rvalid`, `lsu_err`, `mem_req`, `mem_we` and `busy` are 0.
  - `mem_addr`, `mem_wdata`, `mem_be`, rdata registers and the streak counter are 0.
  - The FSM is in IDLE.
- **Zero-wait read sequence:**
  - C0: gnt.
  - C1: `mem_req` & `mem_ready`.
  - C2: `mem_rvalid`.
  - C3: `rvalid` asserted; a new gnt is possible in C3.
- **Zero-wait write sequence:**
  - C0: gnt.
  - C1: `mem_req` & `mem_ready`.
  - C2: `lsu_rvalid`; a new gnt is possible in C2.
- No grant is given while `busy` is high.
- **Reset mid-transaction:**
  - The FSM returns to IDLE and `mem_req` drops at the next edge.
  - The pending response is discarded with no `rvalid`.
  - The memory is reset by the same `reset`.
- **Simultaneous events:** a `req` arriving in the same cycle that `rvalid` is emitted is granted in that cycle if the FSM is in IDLE.

## Configuration
- **`MEM_ARB_MISALIGN_CHECK_EN` defined:**
  - At arbitration, an LSU request with `lsu_addr[1:0] != 0` and `lsu_be == all ones` is granted but not issued.
  - The next cycle, `lsu_rvalid` = 1 and `lsu_err` = 1, `lsu_rdata` is unchanged, and the FSM stays in IDLE.
  - The misaligned grant still updates the streak counter.
- **`MEM_ARB_MISALIGN_CHECK_EN` undefined:**
  - `lsu_err` is tied to 0.
  - All requests are issued unchanged.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT_RESP).
  - Owner enum (OWNER_IF/OWNER_LSU).
  - Streak counter width constant (4).
- Sub-module `mem_arb_priority`: contains the winner selection and the streak counter. Inputs: `if_req`, `lsu_req`, `grant_en`. Outputs: `sel_if`, `sel_lsu`.

## Test plan
- **Lone fetch read:**
  - Stimulus: `if_req` with `if_addr` = 0x100; memory returns 0xDEADBEEF with zero wait.
  - Expected: `if_gnt` at C0, `mem_addr` = 0x100 at C1, `if_rvalid` with `if_rdata` = 0xDEADBEEF at C3; `busy` high in C1–C2.
- **LSU write with wait states:**
  - Stimulus: `mem_ready` held low for 3 cycles.
  - Expected: `mem_req`/`mem_addr`/`mem_wdata` stable across all 4 ISSUE cycles; `lsu_rvalid` one cycle after `mem_ready`.
- **Contention fairness:**
  - Stimulus: `if_req` and `lsu_req` held high continuously with `LSU_STREAK_MAX` = 4.
  - Expected: grant order is L,L,L,L,I,L,L,L,L,I.
- **Reset mid-operation:**
  - Stimulus: `reset` asserted in WAIT_RESP, then `mem_rvalid` = 1 after reset.
  - Expected: no `rvalid` emitted; `mem_req` = 0 and `busy` = 0 the cycle after reset.
- **Misaligned access (macro defined):**
  - Stimulus: `lsu_addr` = 0x102, `lsu_be` = 0xF.
  - Expected: `mem_req` never asserted; `lsu_rvalid` = `lsu_err` = 1 the next cycle.
- **Misaligned access (macro undefined):** same stimulus is issued with `mem_addr` = 0x102 and `lsu_err` = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and streak counter width for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  typedef enum logic {OWNER_IF, OWNER_LSU} owner_t;
  localparam int STREAK_W = 4;
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: LSU-first winner selection with a streak limit that forces a waiting fetch through
module mem_arb_priority #(
  parameter int STREAK_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic lsu_req,
  input  logic grant_en,
  output logic sel_if,
  output logic sel_lsu
);
  import mem_arb_pkg::*;
  logic [STREAK_W-1:0] streak;
  always_comb begin
    sel_lsu = grant_en && lsu_req && !(if_req && streak == STREAK_W'(STREAK_MAX));
    sel_if  = grant_en && if_req && !sel_lsu;
  end
  // Only contested LSU wins count toward the limit; any fetch win restarts it.
  always_ff @(posedge clk) begin
    if (reset) streak <= '0;
    else if (sel_if) streak <= '0;
    else if (sel_lsu && if_req && streak != '1) streak <= streak + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// MEM_ARB_MISALIGN_CHECK_EN: misaligned full-word LSU requests are answered with lsu_err instead of issued.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LSU_STREAK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    lsu_req,
  input  logic                    lsu_we,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_be,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    lsu_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);
  import mem_arb_pkg::*;
  state_t state, state_n;
  owner_t owner;
  logic sel_if, sel_lsu, misalign, resp;
  mem_arb_priority #(.STREAK_MAX(LSU_STREAK_MAX)) u_priority (
    .clk(clk), .reset(reset), .if_req(if_req), .lsu_req(lsu_req),
    .grant_en(state == IDLE), .sel_if(sel_if), .sel_lsu(sel_lsu)
  );
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign misalign = sel_lsu && lsu_addr[1:0] != 2'b00 && lsu_be == '1;
  always_ff @(posedge clk) lsu_err <= !reset && misalign;
`else
  assign misalign = 1'b0;
  assign lsu_err  = 1'b0;
`endif
  assign if_gnt  = sel_if;
  assign lsu_gnt = sel_lsu;
  assign busy    = state != IDLE;
  assign mem_req = state == ISSUE;
  assign resp    = state == WAIT_RESP && mem_rvalid;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (sel_if || (sel_lsu && !misalign)) ? ISSUE : IDLE;
      ISSUE:     state_n = mem_ready ? (mem_we ? IDLE : WAIT_RESP) : ISSUE;
      WAIT_RESP: state_n = mem_rvalid ? IDLE : WAIT_RESP;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_IF;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rvalid  <= 1'b0;
      lsu_rvalid <= 1'b0;
      if_rdata   <= '0;
      lsu_rdata  <= '0;
    end else begin
      state      <= state_n;
      if_rvalid  <= resp && owner == OWNER_IF;
      lsu_rvalid <= (resp && owner == OWNER_LSU) || (state == ISSUE && mem_ready && mem_we) || misalign;
      if (resp && owner == OWNER_IF) if_rdata <= mem_rdata;
      if (resp && owner == OWNER_LSU) lsu_rdata <= mem_rdata;
      // Fetch is always a full-word read; a misaligned LSU grant leaves the port untouched.
      if (sel_if) begin
        owner    <= OWNER_IF;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        mem_be   <= '1;
      end else if (sel_lsu && !misalign) begin
        owner     <= OWNER_LSU;
        mem_we    <= lsu_we;
        mem_addr  <= lsu_addr;
        mem_wdata <= lsu_wdata;
        mem_be    <= lsu_be;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and randomized scoreboard run for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0] lsu_be;
  logic mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  int checks = 0, failures = 0;
  int ready_wait = 0, rv_wait = 0;
  bit force_rvalid = 1'b0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory responder: ready after ready_wait idle ISSUE cycles, read data rv_wait cycles after ready.
  logic [31:0] phys [256];
  logic [31:0] rd_q;
  int wcnt = 0, rd_cnt = -1;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rvalid = force_rvalid;
    if (reset) begin
      wcnt = 0;
      rd_cnt = -1;
      mem_rdata = 32'hBAD0BAD0;
      for (int i = 0; i < 256; i++) phys[i] = '0;
    end else begin
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = rd_q;
        rd_cnt = -1;
      end else if (rd_cnt > 0) rd_cnt--;
      if (mem_req) begin
        if (wcnt >= ready_wait) begin
          mem_ready = 1'b1;
          wcnt = 0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_be[b]) phys[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            rd_q = phys[mem_addr[9:2]];
            rd_cnt = rv_wait;
          end
        end else wcnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b0;
    lsu_req = 1'b0;
    force_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit lsu;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    int rwait;
    logic [31:0] exp_rdata;
    int exp_lat;
  } txn_t;

  task automatic run_txn(input txn_t t);
    int rv_at = -1;
    logic [1:0] rv_who = 2'b00;
    @(negedge clk);
    ready_wait = t.rwait;
    rv_wait = 0;
    if_req = !t.lsu;
    if_addr = t.addr;
    lsu_req = t.lsu;
    lsu_we = t.we;
    lsu_addr = t.addr;
    lsu_wdata = t.wdata;
    lsu_be = t.be;
    #1;
    chk("txn_gnt", {if_gnt, lsu_gnt}, t.lsu ? 2'b01 : 2'b10);
    for (int c = 1; c <= 20 && rv_at < 0; c++) begin
      @(negedge clk);
      if_req = 1'b0;
      lsu_req = 1'b0;
      if_addr = ~t.addr;
      lsu_addr = ~t.addr;
      lsu_wdata = ~t.wdata;
      #1;
      if (c <= t.rwait + 1) begin
        chk("txn_mem_req", mem_req, 1);
        chk("txn_mem_addr", mem_addr, t.addr);
        chk("txn_mem_we", mem_we, t.we);
        if (t.we) chk("txn_mem_wdata", mem_wdata, t.wdata);
        if (t.lsu) chk("txn_mem_be", mem_be, t.be);
      end
      if (if_rvalid || lsu_rvalid) begin
        rv_at = c;
        rv_who = {if_rvalid, lsu_rvalid};
      end
      chk("txn_busy", busy, rv_at < 0);
    end
    chk("txn_rvalid_latency", rv_at, t.exp_lat);
    chk("txn_rvalid_owner", rv_who, t.lsu ? 2'b01 : 2'b10);
    if (t.lsu) chk("txn_lsu_err", lsu_err, 0);
    if (!t.we) chk("txn_rdata", t.lsu ? lsu_rdata : if_rdata, t.exp_rdata);
    @(negedge clk);
    #1;
    chk("txn_rvalid_pulse", {if_rvalid, lsu_rvalid}, 0);
  endtask

  task automatic reset_mid_op();
    int rv_count = 0;
    @(negedge clk);
    ready_wait = 0;
    rv_wait = 6;
    if_req = 1'b1;
    if_addr = 32'h100;
    #1;
    chk("rmo_gnt", if_gnt, 1);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("rmo_issue", mem_req, 1);
    @(negedge clk);
    #1;
    chk("rmo_wait_busy", {busy, mem_req}, 2'b10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force_rvalid = 1'b1;
    #1;
    chk("rmo_after_reset", {busy, mem_req}, 2'b00);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) force_rvalid = 1'b0;
      #1;
      rv_count += int'(if_rvalid) + int'(lsu_rvalid);
      chk("rmo_busy_low", busy, 0);
    end
    chk("rmo_no_rvalid", rv_count, 0);
  endtask

  task automatic contention();
    logic [9:0] got = '0;
    int n = 0;
    ready_wait = 0;
    rv_wait = 0;
    lsu_we = 1'b0;
    lsu_addr = 32'h8;
    lsu_be = 4'hF;
    if_addr = 32'h4;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if_req = 1'b1;
      lsu_req = 1'b1;
      #1;
      if (if_gnt || lsu_gnt) begin
        got[n] = if_gnt;
        n++;
      end
    end
    @(negedge clk);
    if_req = 1'b0;
    lsu_req = 1'b0;
    chk("contention_grants", n, 10);
    chk("contention_order", got, 10'b1000010000);
  endtask

  typedef struct {
    bit we;
    logic [31:0] d;
  } lexp_t;

  // Scoreboard: arbitration, busy and response data derived from the rules and a shadow word array.
  task automatic rand_phase(input int n);
    int streak = 0;
    bit outst = 0, drop_if = 0, drop_lsu = 0, rv_now, e_if, e_lsu;
    logic [31:0] exp_if_q[$];
    lexp_t lsu_q[$];
    lexp_t le;
    logic [31:0] refm [16];
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) refm[i] = '0;
    for (int cyc = 0; cyc < n + 300; cyc++) begin
      @(negedge clk);
      if (drop_if) begin
        if_req = 1'b0;
        if_addr = $urandom;
      end
      if (drop_lsu) begin
        lsu_req = 1'b0;
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
      end
      drop_if = 0;
      drop_lsu = 0;
      if (cyc >= n && !if_req && !lsu_req && !outst) break;
      ready_wait = $urandom_range(0, 2);
      rv_wait = $urandom_range(0, 2);
      if (cyc < n && !if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (cyc < n && !lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1'b1;
        lsu_we = 1'($urandom_range(0, 1));
        lsu_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        lsu_wdata = $urandom;
        lsu_be = 4'($urandom_range(1, 15));
      end
      #1;
      rv_now = if_rvalid || lsu_rvalid;
      if (if_rvalid) begin
        if (exp_if_q.size() == 0) chk("rnd_if_spurious_rvalid", 1, 0);
        else chk("rnd_if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (lsu_rvalid) begin
        if (lsu_q.size() == 0) chk("rnd_lsu_spurious_rvalid", 1, 0);
        else begin
          le = lsu_q.pop_front();
          chk("rnd_lsu_err", lsu_err, 0);
          if (!le.we) chk("rnd_lsu_rdata", lsu_rdata, le.d);
        end
      end
      chk("rnd_busy", busy, outst && !rv_now);
      if (rv_now) outst = 0;
      e_lsu = !outst && lsu_req && !(if_req && streak == 4);
      e_if = !outst && if_req && !e_lsu;
      chk("rnd_gnt", {if_gnt, lsu_gnt}, {e_if, e_lsu});
      if (e_if) begin
        exp_if_q.push_back(refm[if_addr[5:2]]);
        streak = 0;
        outst = 1;
        drop_if = 1;
      end
      if (e_lsu) begin
        idx = lsu_addr[5:2];
        if (lsu_we) begin
          for (int b = 0; b < 4; b++) if (lsu_be[b]) refm[idx][8*b +: 8] = lsu_wdata[8*b +: 8];
          lsu_q.push_back('{1'b1, 32'h0});
        end else lsu_q.push_back('{1'b0, refm[idx]});
        if (if_req && streak < 15) streak++;
        outst = 1;
        drop_lsu = 1;
      end
    end
    chk("rnd_drain", {if_req, lsu_req, outst, 1'(exp_if_q.size() != 0), 1'(lsu_q.size() != 0)}, 0);
  endtask

  txn_t tbl [9];
  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0, 2};
    tbl[1] = '{1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF, 3};
    tbl[2] = '{1'b1, 1'b1, 32'h040, 32'h11223344, 4'hF, 3, 32'h0, 5};
    tbl[3] = '{1'b1, 1'b1, 32'h040, 32'hAAAABBBB, 4'h3, 1, 32'h0, 3};
    tbl[4] = '{1'b1, 1'b0, 32'h040, 32'h0, 4'hF, 2, 32'h1122BBBB, 5};
    tbl[5] = '{1'b0, 1'b0, 32'h044, 32'h0, 4'hF, 0, 32'h0, 3};
    tbl[6] = '{1'b1, 1'b1, 32'h044, 32'h55667788, 4'hC, 0, 32'h0, 2};
    tbl[7] = '{1'b0, 1'b0, 32'h044, 32'h0, 4'hF, 1, 32'h55660000, 4};
    tbl[8] = '{1'b1, 1'b0, 32'h102, 32'h0, 4'hF, 0, 32'hDEADBEEF, 3};
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    lsu_req = 1'b0;
    lsu_we = 1'b0;
    lsu_addr = '0;
    lsu_wdata = '0;
    lsu_be = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, lsu_err, mem_req, mem_we, busy}, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_mem_be", mem_be, 0);
    chk("reset_rdata", {if_rdata, lsu_rdata}, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    @(negedge clk);
    lsu_req = 1'b1;
    lsu_we = 1'b0;
    lsu_addr = 32'h102;
    lsu_be = 4'hF;
    #1;
    chk("mis_gnt", {lsu_gnt, mem_req}, 2'b10);
    @(negedge clk);
    lsu_req = 1'b0;
    #1;
    chk("mis_resp", {lsu_rvalid, lsu_err, busy, mem_req}, 4'b1100);
    chk("mis_rdata_held", lsu_rdata, 32'h1122BBBB);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("mis_quiet", {lsu_rvalid, lsu_err, mem_req, busy}, 0);
    end
`else
    run_txn(tbl[8]);
`endif
    reset_mid_op();
    do_reset();
    contention();
    do_reset();
    rand_phase(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
